// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// ALU opcodes and register-file addresses used on the control bus.
package instruction_sequencer_pkg;

    typedef enum logic [4:0] {
        S_IF1   = 5'd0,
        S_D1    = 5'd1,
        S_IF2   = 5'd2,
        S_D2    = 5'd3,
        S_IF3   = 5'd4,
        S_D3    = 5'd5,
        S_PUSH1 = 5'd6,
        S_PUSH2 = 5'd7,
        S_POP1  = 5'd8,
        S_POP2  = 5'd9,
        S_EXE   = 5'd10,
        S_RD    = 5'd11,
        S_WR    = 5'd12,
        S_INT1  = 5'd13,
        S_INT2  = 5'd14,
        S_INT3  = 5'd15
    } seq_state_e;

    localparam logic [5:0] ALU_MOV = 6'h00;
    localparam logic [5:0] ALU_DEC = 6'h08;
    localparam logic [5:0] ALU_INC = 6'h1B;

    localparam logic [3:0] REG_IR1  = 4'h0;
    localparam logic [3:0] REG_IR2  = 4'h1;
    localparam logic [3:0] REG_IV   = 4'h2;
    localparam logic [3:0] REG_IR3  = 4'h3;
    localparam logic [3:0] REG_FLAG = 4'h4;
    localparam logic [3:0] REG_MEM  = 4'hB;
    localparam logic [3:0] REG_ADDR = 4'hC;
    localparam logic [3:0] REG_IP   = 4'hD;
    localparam logic [3:0] REG_SP   = 4'hE;
    localparam logic [3:0] REG_ZR   = 4'hF;

endpackage

// File: rtl/instruction_sequencer_bus_map.sv
// Turns a raw (dest, s1, s2) triple into the bus form: the MEM pseudo-register
// becomes a memory read or write strobe and is replaced by ZR on the bus.
module seq_bus_map
    import instruction_sequencer_pkg::*;
(
    input  logic [3:0] raw_dest,
    input  logic [3:0] raw_s1,
    input  logic [3:0] raw_s2,
    output logic [3:0] dest,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic       mem_rd,
    output logic       mem_wr
);

    // A write to MEM takes priority over any read operand.
    always_comb begin
        dest   = raw_dest;
        s1     = raw_s1;
        s2     = raw_s2;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        if (raw_dest == REG_MEM) begin
            mem_wr = 1'b1;
            dest   = REG_ZR;
        end else if (raw_s1 == REG_MEM || raw_s2 == REG_MEM) begin
            mem_rd = 1'b1;
            s1     = REG_ZR;
            s2     = REG_ZR;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Microcoded instruction sequencer: walks fetch/decode/execute states and
// drives the ALU/register/memory control word for each cycle.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int MEM_HS   = 1,
    parameter int IRQ_EN   = 1,
    parameter int ALU_OP_W = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [15:0]         i_ir1,
    input  logic [15:0]         i_ir2,
    input  logic                i_mem_ready,
    input  logic                i_irq,
    input  logic                i_int_en,
    output logic [4:0]          o_state,
    output logic                o_err,
    output logic                o_int_ack,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic [3:0]          o_s1,
    output logic [3:0]          o_s2,
    output logic [3:0]          o_dest,
    output logic                o_mem_rd,
    output logic                o_mem_wr
);

    seq_state_e state, state_next;

    logic [3:0] inst, ra1, ra2, ra3;
    logic       is_op, is_push, is_pop, is_call, is_load, is_store, is_illegal, is_im16;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic [3:0] raw_dest, raw_s1, raw_s2;
    logic       stall;
    logic       unused_ir_bits;

    assign inst       = i_ir1[15:12];
    assign ra1        = i_ir1[3:0];
    assign ra2        = i_ir2[15:12];
    assign ra3        = i_ir2[11:8];
    assign is_op      = (inst[3:2] == 2'b00);
    assign is_push    = (inst == 4'hC);
    assign is_pop     = (inst == 4'hD);
    assign is_call    = (inst == 4'hB);
    assign is_load    = (inst == 4'h8);
    assign is_store   = (inst == 4'h9);
    assign is_illegal = (inst == 4'hA) || (inst == 4'hE) || (inst == 4'hF);
    assign is_im16    = (ra2 == 4'h3) || (ra3 == 4'h3);
    assign dec_alu_op = is_op ? ALU_OP_W'(i_ir1[13:8]) : ALU_OP_W'(i_ir1[11:8]);
    assign unused_ir_bits = ^{i_ir1[7:4], i_ir2[7:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IF1;
        else          state <= state_next;
    end

    always_comb begin
        o_alu_op  = ALU_OP_W'(ALU_MOV);
        raw_dest  = REG_ZR;
        raw_s1    = REG_ZR;
        raw_s2    = REG_ZR;
        o_err     = 1'b0;
        o_int_ack = 1'b0;
        case (state)
            S_IF1:  begin raw_dest = REG_IR1; raw_s1 = REG_MEM; end
            S_IF2:  begin raw_dest = REG_IR2; raw_s1 = REG_MEM; end
            S_IF3:  begin raw_dest = REG_IR3; raw_s1 = REG_MEM; end
            S_D1, S_D2, S_D3: begin
                o_alu_op = ALU_OP_W'(ALU_INC);
                raw_dest = REG_IP;
                raw_s1   = REG_IP;
                o_err    = (state == S_D1) && is_illegal;
            end
            S_PUSH1, S_INT1: begin
                o_alu_op = ALU_OP_W'(ALU_DEC);
                raw_dest = REG_SP;
                raw_s1   = REG_SP;
            end
            S_PUSH2, S_WR: begin raw_dest = REG_MEM; raw_s1 = ra1; end
            S_POP1, S_RD:  begin raw_dest = ra1; raw_s1 = REG_MEM; end
            S_POP2: begin
                o_alu_op = ALU_OP_W'(ALU_INC);
                raw_dest = REG_SP;
                raw_s1   = REG_SP;
            end
            S_EXE: begin
                o_alu_op = dec_alu_op;
                raw_dest = ra1;
                raw_s1   = ra2;
                raw_s2   = ra3;
            end
            S_INT2: begin raw_dest = REG_MEM; raw_s1 = REG_IP; end
            S_INT3: begin raw_dest = REG_IP; raw_s1 = REG_IV; o_int_ack = 1'b1; end
            default: o_err = 1'b1;
        endcase
    end

    seq_bus_map u_bus_map (
        .raw_dest (raw_dest),
        .raw_s1   (raw_s1),
        .raw_s2   (raw_s2),
        .dest     (o_dest),
        .s1       (o_s1),
        .s2       (o_s2),
        .mem_rd   (o_mem_rd),
        .mem_wr   (o_mem_wr)
    );

    // Memory states freeze here until the access completes; the interrupt
    // request is therefore only acted on at the edge where IF1 really leaves.
    assign stall = (MEM_HS != 0) && (o_mem_rd || o_mem_wr) && !i_mem_ready;

    always_comb begin
        state_next = S_IF1;
        case (state)
            S_IF1:   state_next = ((IRQ_EN != 0) && i_irq && i_int_en) ? S_INT1 : S_D1;
            S_D1: begin
                if (is_push)         state_next = S_PUSH1;
                else if (is_pop)     state_next = S_POP1;
                else if (is_illegal) state_next = S_IF1;
                else                 state_next = S_IF2;
            end
            S_IF2:   state_next = S_D2;
            S_D2: begin
                if (is_im16)      state_next = S_IF3;
                else if (is_call) state_next = S_PUSH1;
                else              state_next = S_EXE;
            end
            S_IF3:   state_next = S_D3;
            S_D3:    state_next = is_call ? S_PUSH1 : S_EXE;
            S_PUSH1: state_next = S_PUSH2;
            S_PUSH2: state_next = is_call ? S_EXE : S_IF1;
            S_POP1:  state_next = S_POP2;
            S_POP2:  state_next = S_IF1;
            S_EXE: begin
                if (is_load)       state_next = S_RD;
                else if (is_store) state_next = S_WR;
                else               state_next = S_IF1;
            end
            S_RD, S_WR: state_next = S_IF1;
            S_INT1:  state_next = S_INT2;
            S_INT2:  state_next = S_INT3;
            S_INT3:  state_next = S_IF1;
            default: state_next = S_IF1;
        endcase
        if (stall) state_next = state;
    end

    assign o_state = state;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed, table-driven bench for instruction_sequencer: one vector per clock,
// plus a hand-written store sequence interrupted by reset while stalled.
module tb_instruction_sequencer;

    typedef struct {
        logic [15:0] ir1;
        logic [15:0] ir2;
        logic        ready;
        logic        irq;
        logic        int_en;
        logic [4:0]  st;
        logic [5:0]  alu;
        logic [3:0]  dest;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        rd;
        logic        wr;
        logic        err;
        logic        ack;
    } vec_t;

    logic        i_clk;
    logic        i_rst_n;
    logic [15:0] i_ir1;
    logic [15:0] i_ir2;
    logic        i_mem_ready;
    logic        i_irq;
    logic        i_int_en;
    logic [4:0]  o_state;
    logic        o_err;
    logic        o_int_ack;
    logic [5:0]  o_alu_op;
    logic [3:0]  o_s1;
    logic [3:0]  o_s2;
    logic [3:0]  o_dest;
    logic        o_mem_rd;
    logic        o_mem_wr;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    instruction_sequencer #(.MEM_HS(1), .IRQ_EN(1), .ALU_OP_W(6)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ir1       (i_ir1),
        .i_ir2       (i_ir2),
        .i_mem_ready (i_mem_ready),
        .i_irq       (i_irq),
        .i_int_en    (i_int_en),
        .o_state     (o_state),
        .o_err       (o_err),
        .o_int_ack   (o_int_ack),
        .o_alu_op    (o_alu_op),
        .o_s1        (o_s1),
        .o_s2        (o_s2),
        .o_dest      (o_dest),
        .o_mem_rd    (o_mem_rd),
        .o_mem_wr    (o_mem_wr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic vec_t mk(input logic [15:0] ir1, input logic [15:0] ir2,
                                input logic ready, input logic irq, input logic int_en,
                                input logic [4:0] st, input logic [5:0] alu,
                                input logic [3:0] dest, input logic [3:0] s1, input logic [3:0] s2,
                                input logic rd, input logic wr, input logic err, input logic ack);
        vec_t v;
        v.ir1 = ir1; v.ir2 = ir2; v.ready = ready; v.irq = irq; v.int_en = int_en;
        v.st = st; v.alu = alu; v.dest = dest; v.s1 = s1; v.s2 = s2;
        v.rd = rd; v.wr = wr; v.err = err; v.ack = ack;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        i_ir1       = v.ir1;
        i_ir2       = v.ir2;
        i_mem_ready = v.ready;
        i_irq       = v.irq;
        i_int_en    = v.int_en;
    endtask

    task automatic compareField(input string name, input int idx,
                                input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp_v);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        compareField("state",   idx, {3'b0, o_state},   {3'b0, v.st});
        compareField("alu_op",  idx, {2'b0, o_alu_op},  {2'b0, v.alu});
        compareField("dest",    idx, {4'b0, o_dest},    {4'b0, v.dest});
        compareField("s1",      idx, {4'b0, o_s1},      {4'b0, v.s1});
        compareField("s2",      idx, {4'b0, o_s2},      {4'b0, v.s2});
        compareField("mem_rd",  idx, {7'b0, o_mem_rd},  {7'b0, v.rd});
        compareField("mem_wr",  idx, {7'b0, o_mem_wr},  {7'b0, v.wr});
        compareField("err",     idx, {7'b0, o_err},     {7'b0, v.err});
        compareField("int_ack", idx, {7'b0, o_int_ack}, {7'b0, v.ack});
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        // ALU op, then IF1 wait states, then a non-memory state ignoring ready
        vecs.push_back(mk(16'h1205, 16'h6700, 1, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 1, 0, 0,  1, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 1, 0, 0,  2, 6'h00, 4'h1, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 1, 0, 0,  3, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 1, 0, 0, 10, 6'h12, 4'h5, 4'h6, 4'h7, 0, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 0, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 0, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 0, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 1, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 0, 0, 0,  1, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 1, 0, 0,  2, 6'h00, 4'h1, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 1, 0, 0,  3, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'h1205, 16'h6700, 1, 0, 0, 10, 6'h12, 4'h5, 4'h6, 4'h7, 0, 0, 0, 0));
        // illegal opcode: err only in D1
        vecs.push_back(mk(16'hA000, 16'h6700, 1, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'hA000, 16'h6700, 1, 0, 0,  1, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 1, 0));
        // irq with interrupts disabled, push path
        vecs.push_back(mk(16'hC003, 16'h6700, 1, 1, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'hC003, 16'h6700, 1, 1, 0,  1, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'hC003, 16'h6700, 1, 0, 0,  6, 6'h08, 4'hE, 4'hE, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'hC003, 16'h6700, 1, 0, 0,  7, 6'h00, 4'hF, 4'h3, 4'hF, 0, 1, 0, 0));
        // interrupt entry
        vecs.push_back(mk(16'hC003, 16'h6700, 1, 1, 1,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'hC003, 16'h6700, 1, 0, 0, 13, 6'h08, 4'hE, 4'hE, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'hC003, 16'h6700, 1, 0, 0, 14, 6'h00, 4'hF, 4'hD, 4'hF, 0, 1, 0, 0));
        vecs.push_back(mk(16'hC003, 16'h6700, 1, 0, 0, 15, 6'h00, 4'hD, 4'h2, 4'hF, 0, 0, 0, 1));
        // interrupt beats a pending illegal opcode
        vecs.push_back(mk(16'hA000, 16'h6700, 1, 1, 1,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'hA000, 16'h6700, 1, 0, 0, 13, 6'h08, 4'hE, 4'hE, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'hA000, 16'h6700, 1, 0, 0, 14, 6'h00, 4'hF, 4'hD, 4'hF, 0, 1, 0, 0));
        vecs.push_back(mk(16'hA000, 16'h6700, 1, 0, 0, 15, 6'h00, 4'hD, 4'h2, 4'hF, 0, 0, 0, 1));
        // call with a 16-bit immediate
        vecs.push_back(mk(16'hB00D, 16'h3000, 1, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'hB00D, 16'h3000, 1, 0, 0,  1, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'hB00D, 16'h3000, 1, 0, 0,  2, 6'h00, 4'h1, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'hB00D, 16'h3000, 1, 0, 0,  3, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'hB00D, 16'h3000, 1, 0, 0,  4, 6'h00, 4'h3, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'hB00D, 16'h3000, 1, 0, 0,  5, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'hB00D, 16'h3000, 1, 0, 0,  6, 6'h08, 4'hE, 4'hE, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'hB00D, 16'h3000, 1, 0, 0,  7, 6'h00, 4'hF, 4'hD, 4'hF, 0, 1, 0, 0));
        vecs.push_back(mk(16'hB00D, 16'h3000, 1, 0, 0, 10, 6'h00, 4'hD, 4'h3, 4'h0, 0, 0, 0, 0));
        // pop
        vecs.push_back(mk(16'hD004, 16'h6700, 1, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'hD004, 16'h6700, 1, 0, 0,  1, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'hD004, 16'h6700, 1, 0, 0,  8, 6'h00, 4'h4, 4'hF, 4'hF, 1, 0, 0, 0));
        vecs.push_back(mk(16'hD004, 16'h6700, 1, 0, 0,  9, 6'h1B, 4'hE, 4'hE, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(16'hD004, 16'h6700, 1, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0));

        i_rst_n = 1'b0;
        applyStimulus(mk(16'h1205, 16'h6700, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        step();
        #1;
        checkOutput(mk(16'h1205, 16'h6700, 0, 1, 1, 0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0), 0);
        i_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i + 1);
            step();
        end

        // Store that stalls in WR and is then abandoned by an async reset.
        i_rst_n = 1'b0;
        #1;
        i_rst_n = 1'b1;
        applyStimulus(mk(16'h9305, 16'h1200, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput(mk(16'h9305, 16'h1200, 1, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0), 100);
        step(); #1;
        checkOutput(mk(16'h9305, 16'h1200, 1, 0, 0,  1, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0), 101);
        step(); #1;
        checkOutput(mk(16'h9305, 16'h1200, 1, 0, 0,  2, 6'h00, 4'h1, 4'hF, 4'hF, 1, 0, 0, 0), 102);
        step(); #1;
        checkOutput(mk(16'h9305, 16'h1200, 1, 0, 0,  3, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0), 103);
        step(); #1;
        checkOutput(mk(16'h9305, 16'h1200, 1, 0, 0, 10, 6'h03, 4'h5, 4'h1, 4'h2, 0, 0, 0, 0), 104);
        step();
        i_mem_ready = 1'b0;
        #1;
        checkOutput(mk(16'h9305, 16'h1200, 0, 0, 0, 12, 6'h00, 4'hF, 4'h5, 4'hF, 0, 1, 0, 0), 105);
        step(); #1;
        checkOutput(mk(16'h9305, 16'h1200, 0, 0, 0, 12, 6'h00, 4'hF, 4'h5, 4'hF, 0, 1, 0, 0), 106);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput(mk(16'h9305, 16'h1200, 0, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0), 107);
        @(negedge i_clk);
        i_rst_n     = 1'b1;
        i_mem_ready = 1'b1;
        #1;
        checkOutput(mk(16'h9305, 16'h1200, 1, 0, 0,  0, 6'h00, 4'h0, 4'hF, 4'hF, 1, 0, 0, 0), 108);
        step(); #1;
        checkOutput(mk(16'h9305, 16'h1200, 1, 0, 0,  1, 6'h1B, 4'hD, 4'hD, 4'hF, 0, 0, 0, 0), 109);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
